// File: rtl/qedmma_pkg.sv
// -----------------------------------------------------------------------------
// qedmma_pkg
// Shared definitions for the QEDMMA track scheduler:
//   MAX_TARGETS   - largest number of target tracks the scheduler can serve
//   TGT_ID_W      - width of a target index
//   sched_state_t - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package qedmma_pkg;

    localparam int MAX_TARGETS = 8;
    localparam int TGT_ID_W    = $clog2(MAX_TARGETS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/qedmma_rr_arbiter.sv
// -----------------------------------------------------------------------------
// qedmma_rr_arbiter
// Combinational rotating-priority selector. Scans the request mask starting at
// start_i, wrapping modulo N; the first set bit found wins.
// Ports:
//   mask_i      [N-1:0]    request mask
//   start_i     [ID_W-1:0] index with highest priority (must be < N)
//   grant_o     [ID_W-1:0] winning index (0 when nothing is requested)
//   any_valid_o            high when at least one mask bit is set
// -----------------------------------------------------------------------------
module qedmma_rr_arbiter #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    mask_i,
    input  logic [ID_W-1:0] start_i,
    output logic [ID_W-1:0] grant_o,
    output logic            any_valid_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_valid_o && mask_i[idx]) begin
                any_valid_o = 1'b1;
                grant_o     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/qedmma_track_scheduler.sv
// -----------------------------------------------------------------------------
// qedmma_track_scheduler
// Time-shares one filter datapath between N_TGT target tracks. Update requests
// are collected into a pending mask; an IDLE/ISSUE/WAIT/DONE FSM picks one
// pending target at a time in round-robin order, starts the datapath, waits for
// its completion and reports it on a one-hot done pulse.
//
// Optional feature: define QEDMMA_SCHED_TIMEOUT_EN to enable a WAIT watchdog
// that aborts a job after TIMEOUT_CYC cycles and sets the sticky timeout_err.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   en           permits new job selection
//   req_pulse    [N_TGT-1:0] one-cycle update requests, one bit per target
//   dp_start     one-cycle job start to the datapath (the ISSUE cycle)
//   dp_tgt_id    [TGT_ID_W-1:0] target of the current job
//   dp_done      datapath completion pulse (only observed in WAIT)
//   done_tgt     [N_TGT-1:0] one-hot completion pulse
//   pending      [N_TGT-1:0] registered pending mask
//   busy         FSM not in IDLE
//   overrun_cnt  [15:0] saturating count of cycles with dropped requests
//   timeout_err  sticky watchdog flag (0 when the watchdog is not built)
// -----------------------------------------------------------------------------
module qedmma_track_scheduler
    import qedmma_pkg::*;
#(
    parameter int N_TGT       = MAX_TARGETS,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_TGT-1:0]    req_pulse,
    output logic                dp_start,
    output logic [TGT_ID_W-1:0] dp_tgt_id,
    input  logic                dp_done,
    output logic [N_TGT-1:0]    done_tgt,
    output logic [N_TGT-1:0]    pending,
    output logic                busy,
    output logic [15:0]         overrun_cnt,
    output logic                timeout_err
);

    if (N_TGT < 2 || N_TGT > MAX_TARGETS) begin : g_bad_n_tgt
        $error("qedmma_track_scheduler: N_TGT out of range");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("qedmma_track_scheduler: TIMEOUT_CYC must be at least 1");
    end

    sched_state_t        state_q, state_d;
    logic [N_TGT-1:0]    pending_q, pending_d;
    logic [TGT_ID_W-1:0] id_q, id_d;
    logic [TGT_ID_W-1:0] last_id_q, last_id_d;
    logic [15:0]         ovr_q, ovr_d;

    logic [N_TGT-1:0]    clr;
    logic [TGT_ID_W-1:0] rr_start;
    logic [TGT_ID_W-1:0] grant;
    logic                any_valid;
    logic                ovr_hit;

`ifdef QEDMMA_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            tmo_q, tmo_d;
`endif

    // Search begins just after the last serviced target.
    assign rr_start = (last_id_q == TGT_ID_W'(N_TGT - 1)) ? '0 : last_id_q + 1'b1;

    qedmma_rr_arbiter #(
        .N    (N_TGT),
        .ID_W (TGT_ID_W)
    ) u_arb (
        .mask_i      (pending_q),
        .start_i     (rr_start),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        clr       = '0;
`ifdef QEDMMA_SCHED_TIMEOUT_EN
        tmo_d     = tmo_q;
        wdog_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (en && any_valid) begin
                    clr     = N_TGT'(1) << grant;
                    id_d    = grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (dp_done) begin
                    state_d = DONE;
                end
`ifdef QEDMMA_SCHED_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            DONE: begin
                last_id_d = id_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request arriving in the same cycle its bit is cleared re-arms it.
        pending_d = (pending_q & ~clr) | req_pulse;

        ovr_hit = |(req_pulse & pending_q & ~clr);
        ovr_d   = (ovr_hit && (ovr_q != 16'hFFFF)) ? ovr_q + 16'd1 : ovr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            id_q      <= '0;
            last_id_q <= TGT_ID_W'(N_TGT - 1);
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef QEDMMA_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign dp_start    = (state_q == ISSUE);
    assign dp_tgt_id   = id_q;
    assign done_tgt    = (state_q == DONE) ? (N_TGT'(1) << id_q) : '0;
    assign pending     = pending_q;
    assign busy        = (state_q != IDLE);
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_qedmma_track_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qedmma_track_scheduler
// Directed bench for qedmma_track_scheduler (N_TGT=8, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_qedmma_track_scheduler;
    import qedmma_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [7:0]          req_pulse;
    logic                dp_start;
    logic [TGT_ID_W-1:0] dp_tgt_id;
    logic                dp_done;
    logic [7:0]          done_tgt;
    logic [7:0]          pending;
    logic                busy;
    logic [15:0]         overrun_cnt;
    logic                timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    qedmma_track_scheduler #(
        .N_TGT       (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_pulse   (req_pulse),
        .dp_start    (dp_start),
        .dp_tgt_id   (dp_tgt_id),
        .dp_done     (dp_done),
        .done_tgt    (done_tgt),
        .pending     (pending),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (dp_start !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check("start_seen", 32'(dp_start), 32'd1);
    endtask

    // Completes one job: waits for its start, answers dp_done d cycles later.
    task automatic serve(input int exp_id, input int d);
        wait_start();
        check("serve_id", 32'(dp_tgt_id), 32'(exp_id));
        step(d);
        dp_done = 1'b1;
        step(1);
        dp_done = 1'b0;
        check("serve_done", 32'(done_tgt), 32'(8'(1) << exp_id));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req_pulse = '0;
        dp_done   = 1'b0;
        step(2);

        // Reset state
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_pending",  32'(pending),     32'd0);
        check("rst_start",    32'(dp_start),    32'd0);
        check("rst_id",       32'(dp_tgt_id),   32'd0);
        check("rst_done",     32'(done_tgt),    32'd0);
        check("rst_overrun",  32'(overrun_cnt), 32'd0);
        check("rst_timeout",  32'(timeout_err), 32'd0);
        rst = 1'b0;
        step(1);

        // Single request: start two cycles after the pulse, done after dp_done
        req_pulse = 8'h04;
        step(1);
        req_pulse = 8'h00;
        check("single_pend",  32'(pending),  32'h04);
        check("single_nost",  32'(dp_start), 32'd0);
        step(1);
        check("single_start", 32'(dp_start), 32'd1);
        check("single_id",    32'(dp_tgt_id), 32'd2);
        step(5);
        dp_done = 1'b1;
        step(1);
        dp_done = 1'b0;
        check("single_done",  32'(done_tgt), 32'h04);
        step(1);
        check("single_done1", 32'(done_tgt), 32'h00);
        check("single_clr",   32'(pending),  32'h00);
        check("single_idle",  32'(busy),     32'd0);

        // Fairness: all targets at once, then 0 and 7 after target 7 served
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req_pulse = 8'hFF;
        step(1);
        req_pulse = 8'h00;
        for (int k = 0; k < 8; k++) begin
            serve(k, 3);
        end
        step(2);
        req_pulse = 8'h81;
        step(1);
        req_pulse = 8'h00;
        serve(0, 3);
        serve(7, 3);

        // Overrun: target 3 requested twice while target 5 is in WAIT
        step(1);
        req_pulse = 8'h20;
        step(1);
        req_pulse = 8'h00;
        wait_start();
        check("ovr_id5", 32'(dp_tgt_id), 32'd5);
        step(1);
        req_pulse = 8'h08;
        step(2);
        req_pulse = 8'h00;
        check("ovr_cnt",  32'(overrun_cnt), 32'd1);
        check("ovr_pend", 32'(pending),     32'h08);
        dp_done = 1'b1;
        step(1);
        dp_done = 1'b0;
        check("ovr_done5", 32'(done_tgt), 32'h20);
        serve(3, 2);

        // Re-request of the in-service target is not an overrun
        step(1);
        req_pulse = 8'h04;
        step(1);
        req_pulse = 8'h00;
        wait_start();
        check("rereq_id", 32'(dp_tgt_id), 32'd2);
        step(1);
        req_pulse = 8'h04;
        step(1);
        req_pulse = 8'h00;
        check("rereq_cnt",  32'(overrun_cnt), 32'd1);
        check("rereq_pend", 32'(pending),     32'h04);
        dp_done = 1'b1;
        step(1);
        dp_done = 1'b0;
        check("rereq_done", 32'(done_tgt), 32'h04);
        serve(2, 1);

        // Selection clear and new request of the same target coincide
        step(1);
        req_pulse = 8'h02;
        step(1);
        step(1);
        req_pulse = 8'h00;
        check("coin_start", 32'(dp_start),    32'd1);
        check("coin_id",    32'(dp_tgt_id),   32'd1);
        check("coin_pend",  32'(pending),     32'h02);
        check("coin_cnt",   32'(overrun_cnt), 32'd1);
        serve(1, 1);
        serve(1, 1);

        // en low: requests accumulate, nothing starts
        step(1);
        en = 1'b0;
        req_pulse = 8'h0F;
        step(1);
        req_pulse = 8'h00;
        step(3);
        check("en_busy", 32'(busy),    32'd0);
        check("en_pend", 32'(pending), 32'h0F);
        en = 1'b1;
        wait_start();
        check("en_id",    32'(dp_tgt_id), 32'd2);
        check("en_pend2", 32'(pending),   32'h0B);
        step(1);

`ifdef QEDMMA_SCHED_TIMEOUT_EN
        // Watchdog: 16 WAIT cycles without dp_done force DONE
        step(15);
        check("tmo_early_done", 32'(done_tgt),    32'h00);
        check("tmo_early_err",  32'(timeout_err), 32'd0);
        check("tmo_early_busy", 32'(busy),        32'd1);
        step(1);
        check("tmo_done", 32'(done_tgt),    32'h04);
        check("tmo_err",  32'(timeout_err), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("tmo_rst_err", 32'(timeout_err), 32'd0);
        req_pulse = 8'h10;
        step(1);
        req_pulse = 8'h00;
        wait_start();
        check("tmo_next_id", 32'(dp_tgt_id), 32'd4);
        step(1);
`else
        // No watchdog: WAIT holds indefinitely
        step(20);
        check("nowd_busy", 32'(busy),        32'd1);
        check("nowd_err",  32'(timeout_err), 32'd0);
        check("nowd_done", 32'(done_tgt),    32'h00);
`endif

        // Reset while in WAIT abandons the job
        rst = 1'b1;
        step(1);
        check("wrst_busy",    32'(busy),        32'd0);
        check("wrst_start",   32'(dp_start),    32'd0);
        check("wrst_id",      32'(dp_tgt_id),   32'd0);
        check("wrst_done",    32'(done_tgt),    32'h00);
        check("wrst_pend",    32'(pending),     32'h00);
        check("wrst_overrun", 32'(overrun_cnt), 32'd0);
        check("wrst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step(3);
        check("wrst_after_done", 32'(done_tgt), 32'h00);
        check("wrst_after_busy", 32'(busy),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
